// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clk_div_pkg                                                |
// | Purpose : Shared constants and helpers for the multi-channel clock   |
// |           divider (default scale width, reset scale, slice helper).  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package clk_div_pkg;

   // Default width of every scale value and counter
   localparam int c_WIDTH = 26;

   // Scale loaded into every channel at reset: 50 MHz CCLK -> 0.5 Hz out
   localparam logic [c_WIDTH-1:0] c_DEFAULT_SCALE = 26'd49_999_999;

   // Lowest bit index of channel idx inside a packed per-channel bus
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clk_div_channel                                            |
// | Purpose : One divider channel: counter, active/pending scale,        |
// |           registered square-wave output and edge tick strobe.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int               WIDTH         = c_WIDTH,
   parameter logic [WIDTH-1:0] DEFAULT_SCALE = WIDTH'(c_DEFAULT_SCALE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_scale,
   output logic             o_clk_out,
   output logic             o_tick
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_act_scale;
   logic [WIDTH-1:0] r_pend_scale;
   logic             r_pend_valid;
   logic             r_clk_out;
   logic             r_tick;

   // Boundary reached: the current half-period is complete.
   // >= rather than == so a stray count can never run away.
   logic w_boundary;
   assign w_boundary = (r_cnt >= r_act_scale);

   // Counter, scale swap at half-period boundaries, output toggle and tick.
   // The pending-register load sits last so a load coinciding with a
   // boundary or sync survives as the next pending value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_act_scale  <= DEFAULT_SCALE;
         r_pend_scale <= '0;
         r_pend_valid <= 1'b0;
         r_clk_out    <= 1'b0;
         r_tick       <= 1'b0;
      end else begin
         if (i_sync) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            if (r_pend_valid) begin
               r_act_scale  <= r_pend_scale;
               r_pend_valid <= 1'b0;
            end
         end else if (i_en) begin
            if (w_boundary) begin
               r_cnt     <= '0;
               r_clk_out <= ~r_clk_out;
               r_tick    <= 1'b1;
               if (r_pend_valid) begin
                  r_act_scale  <= r_pend_scale;
                  r_pend_valid <= 1'b0;
               end
            end else begin
               r_cnt  <= r_cnt + WIDTH'(1);
               r_tick <= 1'b0;
            end
         end else begin
            r_tick <= 1'b0;
         end

         if (i_load) begin
            r_pend_scale <= i_scale;
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;

endmodule : clk_div_channel
`default_nettype wire

// File: rtl/clk_divider_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clk_divider_multi                                          |
// | Purpose : CHANNELS independent clock dividers sharing CCLK, reset    |
// |           and a global phase-align sync input.                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module clk_divider_multi
   import clk_div_pkg::*;
#(
   parameter int               WIDTH         = c_WIDTH,
   parameter int               CHANNELS      = 4,
   parameter logic [WIDTH-1:0] DEFAULT_SCALE = WIDTH'(c_DEFAULT_SCALE)
) (
   input  logic                      CCLK,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS*WIDTH-1:0] clkscale,
   input  logic [CHANNELS-1:0]       load,
   input  logic                      sync,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS-1:0]       tick
);

   // One divider per channel; only reset and sync are shared
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [WIDTH-1:0] w_scale;
      assign w_scale = clkscale[slice_lo(g, WIDTH) +: WIDTH];

      clk_div_channel #(
         .WIDTH         (WIDTH),
         .DEFAULT_SCALE (DEFAULT_SCALE)
      ) u_channel (
         .clk       (CCLK),
         .rst       (reset),
         .i_en      (en[g]),
         .i_sync    (sync),
         .i_load    (load[g]),
         .i_scale   (w_scale),
         .o_clk_out (clk_out[g]),
         .o_tick    (tick[g])
      );
   end

endmodule : clk_divider_multi
`default_nettype wire

// File: tb/tb_clk_divider_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_clk_divider_multi                                       |
// | Purpose : Self-checking bench: vector table, directed corner-case    |
// |           sequences and randomized run against a reference model.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_clk_divider_multi;

   localparam int c_W   = 26;
   localparam int c_CH  = 4;
   localparam int c_DEF = 7;

   logic                  CCLK;
   logic                  reset;
   logic [c_CH-1:0]       en;
   logic [c_CH*c_W-1:0]   clkscale;
   logic [c_CH-1:0]       load;
   logic                  sync;
   logic [c_CH-1:0]       clk_out;
   logic [c_CH-1:0]       tick;

   int total = 0;
   int bad   = 0;

   // Reference model: cycles remaining until the next edge, per channel
   int   m_rem  [c_CH];
   int   m_act  [c_CH];
   int   m_pend [c_CH];
   bit   m_pv   [c_CH];
   logic [c_CH-1:0] m_lvl;
   logic [c_CH-1:0] m_tk;

   clk_divider_multi #(
      .WIDTH         (c_W),
      .CHANNELS      (c_CH),
      .DEFAULT_SCALE (26'd7)
   ) dut (
      .CCLK     (CCLK),
      .reset    (reset),
      .en       (en),
      .clkscale (clkscale),
      .load     (load),
      .sync     (sync),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   initial CCLK = 1'b0;
   always #5 CCLK = ~CCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_scale(input int ch, input int val);
      clkscale[ch*c_W +: c_W] = c_W'(val);
   endtask

   // Advance the model one CCLK edge using the inputs applied for that edge
   task automatic model_step();
      for (int i = 0; i < c_CH; i++) begin
         if (reset) begin
            m_act[i] = c_DEF; m_pv[i] = 0; m_pend[i] = 0;
            m_lvl[i] = 0; m_tk[i] = 0; m_rem[i] = c_DEF + 1;
         end else begin
            if (sync) begin
               if (m_pv[i]) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
               m_rem[i] = m_act[i] + 1; m_lvl[i] = 0; m_tk[i] = 0;
            end else if (en[i]) begin
               if (m_rem[i] == 1) begin
                  m_lvl[i] = ~m_lvl[i]; m_tk[i] = 1;
                  if (m_pv[i]) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
                  m_rem[i] = m_act[i] + 1;
               end else begin
                  m_rem[i] = m_rem[i] - 1; m_tk[i] = 0;
               end
            end else begin
               m_tk[i] = 0;
            end
            if (load[i]) begin
               m_pend[i] = int'(clkscale[i*c_W +: c_W]);
               m_pv[i]   = 1;
            end
         end
      end
   endtask

   // Apply inputs for one edge, then compare DUT with model just after it
   task automatic step(input logic r, input logic [c_CH-1:0] e,
                       input logic [c_CH-1:0] ld, input logic s);
      reset = r; en = e; load = ld; sync = s;
      @(posedge CCLK);
      #1;
      model_step();
      chk("model_clk_out", 32'(clk_out), 32'(m_lvl));
      chk("model_tick",    32'(tick),    32'(m_tk));
   endtask

   typedef struct {
      logic            r;
      logic [c_CH-1:0] e;
      logic [c_CH-1:0] ld;
      logic            s;
      int              sc0;
      int              sc1;
      logic [c_CH-1:0] exp_clk;
      logic [c_CH-1:0] exp_tick;
   } vec_t;

   vec_t tbl [19];

   initial begin
      reset = 1'b1; en = '0; load = '0; sync = 1'b0; clkscale = '0;
      for (int i = 0; i < c_CH; i++) begin
         m_rem[i] = c_DEF + 1; m_act[i] = c_DEF; m_pend[i] = 0; m_pv[i] = 0;
      end
      m_lvl = '0; m_tk = '0;

      // Basic divide table: ch0 scale 3, ch1 scale 1, after reset and sync
      tbl[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 0, 0, 4'b0000, 4'b0000};
      tbl[1] = '{1'b0, 4'b0000, 4'b0011, 1'b0, 3, 1, 4'b0000, 4'b0000};
      tbl[2] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 0, 0, 4'b0000, 4'b0000};
      for (int k = 1; k <= 16; k++) begin
         tbl[k+2] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 0, 0,
                      {2'b00, 1'((k/2) % 2), 1'((k/4) % 2)},
                      {2'b00, 1'(k % 2 == 0), 1'(k % 4 == 0)}};
      end

      // Reset held 3 cycles, then first tick with DEFAULT_SCALE=7 in cycle 8
      for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 4'b0000, 1'b0);
      chk("reset_clk_out", 32'(clk_out), 32'h0);
      chk("reset_tick",    32'(tick),    32'h0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 4'b0001, 4'b0000, 1'b0);
         chk("first_tick", 32'(tick[0]), 32'(k == 8));
      end
      chk("first_clk_out", 32'(clk_out[0]), 32'h1);

      // Table-driven basic divide
      for (int v = 0; v < 19; v++) begin
         set_scale(0, tbl[v].sc0);
         set_scale(1, tbl[v].sc1);
         step(tbl[v].r, tbl[v].e, tbl[v].ld, tbl[v].s);
         chk("vec_clk_out", 32'(clk_out), 32'(tbl[v].exp_clk));
         chk("vec_tick",    32'(tick),    32'(tbl[v].exp_tick));
      end

      // Glitch-free reload: scale 9, load 2 mid-half-period, then a load
      // coincident with a boundary (4 pending, 5 arrives on the boundary)
      set_scale(0, 9);
      step(1'b0, 4'b0000, 4'b0001, 1'b0);
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      for (int k = 1; k <= 27; k++) begin
         logic [c_CH-1:0] ld;
         ld = '0;
         if (k == 5)  begin set_scale(0, 2); ld = 4'b0001; end
         if (k == 14) begin set_scale(0, 4); ld = 4'b0001; end
         if (k == 16) begin set_scale(0, 5); ld = 4'b0001; end
         step(1'b0, 4'b0001, ld, 1'b0);
         chk("reload_tick", 32'(tick[0]),
             32'(k == 10 || k == 13 || k == 16 || k == 21 || k == 27));
      end

      // Enable hold: scale 9, freeze at cnt=5 for 20 cycles, 5 more to tick
      set_scale(0, 9);
      step(1'b0, 4'b0000, 4'b0001, 1'b0);
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b0, 4'b0001, 4'b0000, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 4'b0000, 4'b0000, 1'b0);
         chk("hold_tick",    32'(tick[0]),    32'h0);
         chk("hold_clk_out", 32'(clk_out[0]), 32'h0);
      end
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, 4'b0001, 4'b0000, 1'b0);
         chk("resume_tick", 32'(tick[0]), 32'(k == 5));
      end

      // Sync alignment: scales 4 and 9 with scrambled phases
      set_scale(0, 4); set_scale(1, 9);
      step(1'b0, 4'b0000, 4'b0011, 1'b0);
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      for (int k = 0; k < int'($urandom_range(17, 3)); k++)
         step(1'b0, 4'b0011, 4'b0000, 1'b0);
      for (int k = 0; k < int'($urandom_range(7, 1)); k++)
         step(1'b0, 4'b0001, 4'b0000, 1'b0);
      step(1'b0, 4'b0011, 4'b0000, 1'b1);
      chk("sync_clk_out", 32'(clk_out[1:0]), 32'h0);
      chk("sync_tick",    32'(tick[1:0]),    32'h0);
      for (int k = 1; k <= 30; k++) begin
         step(1'b0, 4'b0011, 4'b0000, 1'b0);
         chk("align_tick", 32'(tick[1:0]),
             32'({1'(k % 10 == 0), 1'(k % 5 == 0)}));
      end

      // Scale 0: output toggles every cycle, tick stays high
      set_scale(0, 0);
      step(1'b0, 4'b0000, 4'b0001, 1'b0);
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 4'b0001, 4'b0000, 1'b0);
         chk("scale0_tick",    32'(tick[0]),    32'h1);
         chk("scale0_clk_out", 32'(clk_out[0]), 32'(k % 2));
      end

      // Reset in the middle of a half-period restores DEFAULT_SCALE
      set_scale(1, 3);
      step(1'b0, 4'b0011, 4'b0010, 1'b0);
      step(1'b0, 4'b0011, 4'b0000, 1'b0);
      step(1'b1, 4'b0011, 4'b0000, 1'b0);
      chk("midreset_clk_out", 32'(clk_out), 32'h0);
      chk("midreset_tick",    32'(tick),    32'h0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 4'b0011, 4'b0000, 1'b0);
         chk("midreset_default", 32'(tick[1:0]), 32'(k == 8 ? 2'b11 : 2'b00));
      end

      // Randomized run against the model
      for (int c = 0; c < 1500; c++) begin
         logic [c_CH-1:0] e, ld;
         logic s, r;
         e = '0; ld = '0;
         for (int i = 0; i < c_CH; i++) begin
            e[i] = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) begin
               ld[i] = 1'b1;
               set_scale(i, int'($urandom_range(5, 0)));
            end
         end
         s = ($urandom_range(63, 0) == 0);
         r = ($urandom_range(255, 0) == 0);
         step(r, e, ld, s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_clk_divider_multi
`default_nettype wire
